// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache.
// Address-field widths are derived from the cache geometry parameters.
package dcache_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MISS_WB,
      S_MISS_RD,
      S_REFILL,
      S_RESOLVE
   } state_t;

   function automatic int calc_offset_w(input int line_words);
      return 2 + $clog2(line_words);
   endfunction

   function automatic int calc_index_w(input int lines);
      return $clog2(lines);
   endfunction

   function automatic int calc_tag_w(input int addr_w, input int lines, input int line_words);
      return addr_w - calc_index_w(lines) - calc_offset_w(line_words);
   endfunction

   // Replace only the byte lanes selected by be.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Cache data storage: byte-writable word port for store hits, full-line write
// port for refills, combinational word and line reads of the addressed set.
module dcache_data_array
   import dcache_pkg::*;
#(
   parameter int LINES      = 64,
   parameter int LINE_WORDS = 4,
   parameter int INDEX_W    = 6,
   parameter int WSEL_W     = 2
) (
   input  logic                    clk,
   input  logic [INDEX_W-1:0]      i_index,
   input  logic [WSEL_W-1:0]       i_word_sel,
   input  logic [3:0]              i_word_be,
   input  logic [31:0]             i_word_data,
   input  logic                    i_line_we,
   input  logic [32*LINE_WORDS-1:0] i_line_data,
   output logic [31:0]             o_word,
   output logic [32*LINE_WORDS-1:0] o_line
);

   logic [31:0] r_mem [LINES][LINE_WORDS];

   always_ff @(posedge clk) begin
      if (i_line_we) begin
         for (int w = 0; w < LINE_WORDS; w++) begin
            r_mem[i_index][w] <= i_line_data[32*w +: 32];
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (i_word_be[b]) r_mem[i_index][i_word_sel][8*b +: 8] <= i_word_data[8*b +: 8];
         end
      end
   end

   assign o_word = r_mem[i_index][i_word_sel];

   for (genvar g = 0; g < LINE_WORDS; g++) begin : g_line
      assign o_line[32*g +: 32] = r_mem[i_index][g];
   end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache between the core's
// dcache port and a line-wide memory arbiter. Hits answer one cycle after accept.
module dcache_direct_mapped
   import dcache_pkg::*;
#(
   parameter int LINES      = 64,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_W-1:0]        dcache_addr,
   input  logic                     dcache_re,
   input  logic [3:0]               dcache_we,
   input  logic [31:0]              dcache_din,
   output logic [31:0]              dcache_dout,
   output logic                     stall,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic                     mem_req_rnw,
   output logic [ADDR_W-1:0]        mem_req_addr,
   output logic [32*LINE_WORDS-1:0] mem_req_data,
   input  logic                     mem_resp_valid,
   input  logic [32*LINE_WORDS-1:0] mem_resp_data
);

   localparam int LINE_BITS = 32 * LINE_WORDS;
   localparam int OFFSET_W  = calc_offset_w(LINE_WORDS);
   localparam int INDEX_W   = calc_index_w(LINES);
   localparam int TAG_W     = calc_tag_w(ADDR_W, LINES, LINE_WORDS);
   localparam int WSEL_W    = OFFSET_W - 2;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_req_vld;
   logic [ADDR_W-1:0]   r_req_addr;
   logic [3:0]          r_req_we;
   logic [31:0]         r_req_din;
   logic [LINES-1:0]    r_valid;
   logic [LINES-1:0]    r_dirty;
   logic [TAG_W-1:0]    r_tag [LINES];

   logic [INDEX_W-1:0]  w_index;
   logic [TAG_W-1:0]    w_req_tag;
   logic [WSEL_W-1:0]   w_word_sel;
   logic                w_hit;
   logic                w_lookup;
   logic                w_stall;
   logic                w_accept;
   logic                w_new;
   logic                w_fill;
   logic [31:0]         w_word;
   logic [LINE_BITS-1:0] w_line;
   logic [LINE_BITS-1:0] w_fill_line;
   logic [3:0]          w_word_be;
   logic                w_unused_lsb;

   assign w_index      = r_req_addr[OFFSET_W +: INDEX_W];
   assign w_req_tag    = r_req_addr[ADDR_W-1 -: TAG_W];
   assign w_word_sel   = r_req_addr[2 +: WSEL_W];
   assign w_unused_lsb = ^r_req_addr[1:0];

   assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_req_tag);
   assign w_lookup = (r_state == S_IDLE) && r_req_vld;
   assign w_new    = dcache_re || (|dcache_we);
   // New requests may enter whenever the core is not stalled, including RESOLVE.
   assign w_accept = !w_stall && ((r_state == S_IDLE) || (r_state == S_RESOLVE));
   assign w_fill   = (r_state == S_REFILL) && mem_resp_valid;
   assign w_word_be = (w_lookup && w_hit) ? r_req_we : 4'b0000;

   // Refill line with any pending store bytes folded into the requested word.
   always_comb begin
      w_fill_line = mem_resp_data;
      w_fill_line[32*w_word_sel +: 32] =
         merge_bytes(mem_resp_data[32*w_word_sel +: 32], r_req_din, r_req_we);
   end

   dcache_data_array #(
      .LINES      (LINES),
      .LINE_WORDS (LINE_WORDS),
      .INDEX_W    (INDEX_W),
      .WSEL_W     (WSEL_W)
   ) u_data (
      .clk         (clk),
      .i_index     (w_index),
      .i_word_sel  (w_word_sel),
      .i_word_be   (w_word_be),
      .i_word_data (r_req_din),
      .i_line_we   (w_fill),
      .i_line_data (w_fill_line),
      .o_word      (w_word),
      .o_line      (w_line)
   );

   assign mem_req_data = w_line;
   assign stall        = w_stall;

   always_comb begin
      w_state_nxt   = r_state;
      w_stall       = 1'b0;
      dcache_dout   = '0;
      mem_req_valid = 1'b0;
      mem_req_rnw   = 1'b0;
      mem_req_addr  = '0;
      unique case (r_state)
         S_IDLE: begin
            if (w_lookup) begin
               if (w_hit) begin
                  dcache_dout = w_word;
               end else begin
                  w_stall     = 1'b1;
                  w_state_nxt = (r_valid[w_index] && r_dirty[w_index]) ? S_MISS_WB : S_MISS_RD;
               end
            end
         end
         S_MISS_WB: begin
            w_stall       = 1'b1;
            mem_req_valid = 1'b1;
            mem_req_addr  = {r_tag[w_index], w_index, {OFFSET_W{1'b0}}};
            if (mem_req_ready) w_state_nxt = S_MISS_RD;
         end
         S_MISS_RD: begin
            w_stall       = 1'b1;
            mem_req_valid = 1'b1;
            mem_req_rnw   = 1'b1;
            mem_req_addr  = {w_req_tag, w_index, {OFFSET_W{1'b0}}};
            if (mem_req_ready) w_state_nxt = S_REFILL;
         end
         S_REFILL: begin
            w_stall = 1'b1;
            if (mem_resp_valid) w_state_nxt = S_RESOLVE;
         end
         S_RESOLVE: begin
            dcache_dout = w_word;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_req_vld  <= 1'b0;
         r_req_addr <= '0;
         r_req_we   <= '0;
         r_req_din  <= '0;
         r_valid    <= '0;
         r_dirty    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_req_vld <= w_new;
            if (w_new) begin
               r_req_addr <= dcache_addr;
               r_req_we   <= dcache_we;
               r_req_din  <= dcache_din;
            end
         end
         if (w_lookup && w_hit && (|r_req_we)) r_dirty[w_index] <= 1'b1;
         if (w_fill) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= |r_req_we;
         end
      end
   end

   // Tags are qualified by r_valid, so they need no reset.
   always_ff @(posedge clk) begin
      if (w_fill) r_tag[w_index] <= w_req_tag;
   end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Self-checking bench for dcache_direct_mapped: directed vector table, hand-written
// reset/refill sequence, and random traffic against a flat-memory reference.
`timescale 1ns/1ps
module tb_dcache_direct_mapped;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  dcache_addr;
   logic         dcache_re;
   logic [3:0]   dcache_we;
   logic [31:0]  dcache_din;
   logic [31:0]  dcache_dout;
   logic         stall;
   logic         mem_req_valid;
   logic         mem_req_ready;
   logic         mem_req_rnw;
   logic [31:0]  mem_req_addr;
   logic [127:0] mem_req_data;
   logic         mem_resp_valid;
   logic [127:0] mem_resp_data;

   always #5 clk = ~clk;

   dcache_direct_mapped dut (
      .clk            (clk),
      .rst            (rst),
      .dcache_addr    (dcache_addr),
      .dcache_re      (dcache_re),
      .dcache_we      (dcache_we),
      .dcache_din     (dcache_din),
      .dcache_dout    (dcache_dout),
      .stall          (stall),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_rnw    (mem_req_rnw),
      .mem_req_addr   (mem_req_addr),
      .mem_req_data   (mem_req_data),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data)
   );

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        rnw;
      logic [31:0] addr;
      logic [127:0] data;
   } req_t;
   req_t req_log[$];

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] din;
      int          hold;
      logic [31:0] exp_dout;
      int          exp_nreq;
      int          exp_nstall;
      logic        r0_rnw;
      logic [31:0] r0_addr;
      logic [31:0] r0_w0;
      logic [31:0] r1_addr;
   } vec_t;

   logic [127:0] mem_store [logic [31:0]];
   logic [31:0]  golden    [logic [31:0]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] mem_line(input logic [31:0] la);
      logic [127:0] l;
      if (mem_store.exists(la)) return mem_store[la];
      for (int w = 0; w < 4; w++) l[32*w +: 32] = la ^ (32'hC0DE0000 + 32'(w) * 32'h01010101);
      return l;
   endfunction

   function automatic logic [31:0] gold_word(input logic [31:0] wa);
      logic [127:0] l;
      if (golden.exists(wa)) return golden[wa];
      l = mem_line(wa & ~32'hF);
      return l[32*wa[3:2] +: 32];
   endfunction

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   // One core access, acting as the memory arbiter while the cache stalls.
   task automatic access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] din,
                         input int hold, output logic [31:0] dout, output int nstall);
      int          held;
      logic        pend;
      logic        done;
      logic [31:0] fill_addr;
      logic [31:0] first_addr;
      logic        first_rnw;
      req_t        r;
      req_log.delete();
      held = 0; pend = 0; done = 0; nstall = 0; dout = '0;
      fill_addr = '0; first_addr = '0; first_rnw = 1'b0;
      @(negedge clk);
      dcache_addr = addr; dcache_we = we; dcache_re = (we == 4'b0); dcache_din = din;
      @(posedge clk); #1;
      dcache_re = 1'b0; dcache_we = 4'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
         if (!stall) begin
            dout = dcache_dout; done = 1'b1;
            dcache_re = 1'b0; dcache_we = 4'b0;
         end else begin
            nstall++;
            dcache_re   = 1'($urandom_range(0, 1));
            dcache_we   = 4'($urandom_range(0, 15));
            dcache_addr = $urandom; dcache_din = $urandom;
            if (pend) begin
               mem_resp_valid = 1'b1; mem_resp_data = mem_line(fill_addr); pend = 1'b0;
            end else if (mem_req_valid) begin
               if (held == 0) begin
                  first_addr = mem_req_addr; first_rnw = mem_req_rnw;
               end else begin
                  chk("req_addr_stable", mem_req_addr, first_addr);
                  chk("req_rnw_stable", 32'(mem_req_rnw), 32'(first_rnw));
               end
               if (held < hold) held++;
               else begin
                  mem_req_ready = 1'b1; held = 0;
                  r.rnw = mem_req_rnw; r.addr = mem_req_addr; r.data = mem_req_data;
                  req_log.push_back(r);
                  if (mem_req_rnw) begin pend = 1'b1; fill_addr = mem_req_addr; end
                  else mem_store[mem_req_addr] = mem_req_data;
               end
            end
         end
      end
      if (!done) chk("stall_timeout", 32'd1, 32'd0);
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      vec_t         vecs[7];
      logic [127:0] l2;
      logic [31:0]  dout, a, wa, din, old, victim;
      logic [3:0]   we;
      logic         hit;
      int           nstall, hold, tag, idx, wd, exp_nreq;
      logic         m_valid[4];
      logic         m_dirty[4];
      int           m_tag[4];

      rst = 1'b1; dcache_addr = '0; dcache_re = 1'b0; dcache_we = 4'b0; dcache_din = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      mem_store[32'h1000] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      repeat (3) @(negedge clk);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_dout", dcache_dout, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("idle_dout", dcache_dout, 32'd0);

      // Directed table: cold miss, hits, byte write, dirty eviction, backpressure.
      l2 = mem_line(32'h2000);
      vecs[0] = '{32'h1004, 4'b0000, 32'h0, 0, 32'h22222222, 1, 3, 1'b1, 32'h1000, 32'h0, 32'h0};
      vecs[1] = '{32'h100C, 4'b0000, 32'h0, 0, 32'h44444444, 0, 0, 1'b0, 32'h0, 32'h0, 32'h0};
      vecs[2] = '{32'h1000, 4'b0011, 32'hAAAABBBB, 0, 32'h11111111, 0, 0, 1'b0, 32'h0, 32'h0, 32'h0};
      vecs[3] = '{32'h1000, 4'b0000, 32'h0, 0, 32'h1111BBBB, 0, 0, 1'b0, 32'h0, 32'h0, 32'h0};
      vecs[4] = '{32'h2000, 4'b0000, 32'h0, 0, l2[31:0], 2, 4, 1'b0, 32'h1000, 32'h1111BBBB, 32'h2000};
      vecs[5] = '{32'h1004, 4'b0000, 32'h0, 5, 32'h22222222, 1, 8, 1'b1, 32'h1000, 32'h0, 32'h0};
      vecs[6] = '{32'h1000, 4'b0000, 32'h0, 0, 32'h1111BBBB, 0, 0, 1'b0, 32'h0, 32'h0, 32'h0};
      for (int i = 0; i < 7; i++) begin
         access(vecs[i].addr, vecs[i].we, vecs[i].din, vecs[i].hold, dout, nstall);
         chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
         chk($sformatf("vec%0d_nreq", i), 32'(req_log.size()), 32'(vecs[i].exp_nreq));
         chk($sformatf("vec%0d_nstall", i), 32'(nstall), 32'(vecs[i].exp_nstall));
         if (vecs[i].exp_nreq > 0 && req_log.size() > 0) begin
            chk($sformatf("vec%0d_req0_rnw", i), 32'(req_log[0].rnw), 32'(vecs[i].r0_rnw));
            chk($sformatf("vec%0d_req0_addr", i), req_log[0].addr, vecs[i].r0_addr);
            if (!vecs[i].r0_rnw)
               chk($sformatf("vec%0d_wb_word0", i), req_log[0].data[31:0], vecs[i].r0_w0);
         end
         if (vecs[i].exp_nreq == 2 && req_log.size() == 2) begin
            chk($sformatf("vec%0d_req1_rnw", i), 32'(req_log[1].rnw), 32'd1);
            chk($sformatf("vec%0d_req1_addr", i), req_log[1].addr, vecs[i].r1_addr);
         end
      end

      // Reset while waiting for refill data; the late response must be ignored.
      @(negedge clk);
      dcache_addr = 32'h3004; dcache_re = 1'b1;
      @(posedge clk); #1;
      dcache_re = 1'b0;
      @(negedge clk);
      chk("rr_lookup_stall", 32'(stall), 32'd1);
      @(negedge clk);
      chk("rr_req_valid", 32'(mem_req_valid), 32'd1);
      chk("rr_req_rnw", 32'(mem_req_rnw), 32'd1);
      chk("rr_req_addr", mem_req_addr, 32'h3000);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("rr_refill_stall", 32'(stall), 32'd1);
      chk("rr_refill_no_req", 32'(mem_req_valid), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rr_after_rst_stall", 32'(stall), 32'd0);
      chk("rr_after_rst_req", 32'(mem_req_valid), 32'd0);
      mem_resp_valid = 1'b1; mem_resp_data = {4{32'hDEADBEEF}};
      @(negedge clk);
      mem_resp_valid = 1'b0;
      chk("rr_late_resp_stall", 32'(stall), 32'd0);
      chk("rr_late_resp_dout", dcache_dout, 32'd0);
      access(32'h1004, 4'b0, 32'h0, 0, dout, nstall);
      chk("rr_remiss_nreq", 32'(req_log.size()), 32'd1);
      chk("rr_remiss_dout", dout, 32'h22222222);
      if (req_log.size() > 0) chk("rr_remiss_addr", req_log[0].addr, 32'h1000);
      l2 = mem_line(32'h3000);
      access(32'h3004, 4'b0, 32'h0, 0, dout, nstall);
      chk("rr_3004_nreq", 32'(req_log.size()), 32'd1);
      chk("rr_3004_dout", dout, l2[63:32]);

      // Random traffic against a flat memory plus per-set occupancy model.
      pulse_reset();
      golden.delete();
      for (int s = 0; s < 4; s++) begin m_valid[s] = 1'b0; m_dirty[s] = 1'b0; m_tag[s] = 0; end
      for (int t = 0; t < 300; t++) begin
         tag  = 32'h10 + $urandom_range(0, 3);
         idx  = $urandom_range(0, 3);
         wd   = $urandom_range(0, 3);
         a    = (32'(tag) << 10) | (32'(idx) << 4) | (32'(wd) << 2) | 32'($urandom_range(0, 3));
         we   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
         din  = $urandom;
         hold = $urandom_range(0, 2);
         wa   = a & ~32'h3;
         hit  = m_valid[idx] && (m_tag[idx] == tag);
         exp_nreq = hit ? 0 : ((m_valid[idx] && m_dirty[idx]) ? 2 : 1);
         victim = (32'(m_tag[idx]) << 10) | (32'(idx) << 4);
         old  = gold_word(wa);
         access(a, we, din, hold, dout, nstall);
         chk("rnd_nreq", 32'(req_log.size()), 32'(exp_nreq));
         chk("rnd_nstall", 32'(nstall), (exp_nreq == 0) ? 32'd0 : 32'(2 + exp_nreq * (1 + hold)));
         if (we == 4'b0 || hit) chk("rnd_dout", dout, old);
         if (exp_nreq == 2 && req_log.size() == 2) begin
            chk("rnd_wb_rnw", 32'(req_log[0].rnw), 32'd0);
            chk("rnd_wb_addr", req_log[0].addr, victim);
         end
         if (!hit) begin m_valid[idx] = 1'b1; m_tag[idx] = tag; m_dirty[idx] = 1'b0; end
         if (we != 4'b0) begin
            m_dirty[idx] = 1'b1;
            golden[wa] = bmerge(old, din, we);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
